imem_loader: RTL



---
 rtl/imem_loader_pkg.sv | 20 ++
 rtl/imem_loader_if.sv | 22 ++
 rtl/imem_loader_word_pack.sv | 34 +++
 rtl/imem_loader.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared constants and FSM encodings for the boot-time instruction loader.
// Imported by imem_loader, loader_word_pack and the loader interface users.
package loader_pkg;

    localparam int BYTE_W         = 8;
    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_BYTES      = 2;

    typedef logic [2:0] state_t;

    localparam state_t S_LEN_HI = 3'd0;
    localparam state_t S_LEN_LO = 3'd1;
    localparam state_t S_DATA   = 3'd2;
    localparam state_t S_CHECK  = 3'd3;
    localparam state_t S_FLUSH  = 3'd4;
    localparam state_t S_DONE   = 3'd5;
    localparam state_t S_ERROR  = 3'd6;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// master: loader side (takes rx bytes, drives mem write); slave: environment.
interface imem_loader_if #(
    parameter int ADDR_WIDTH = 12
);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic                  mem_wEn;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_data;

    modport master (
        input  rx_data, rx_valid,
        output rx_ready, mem_wEn, mem_addr, mem_data
    );

    modport slave (
        output rx_data, rx_valid,
        input  rx_ready, mem_wEn, mem_addr, mem_data
    );
endinterface

// File: rtl/imem_loader_word_pack.sv
// Big-endian 8-to-32 assembler: first byte lands in [31:24].
// Ports: clock, reset (sync, low), clear, in_valid/in_byte, word_valid/word.
module loader_word_pack
    import loader_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_byte,
    output logic              word_valid,
    output logic [WORD_W-1:0] word
);
    localparam logic [1:0] LAST = 2'(BYTES_PER_WORD - 1);

    logic [1:0]  cnt;
    logic [23:0] shreg;

    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            cnt   <= '0;
            shreg <= '0;
        end else if (in_valid) begin
            cnt   <= cnt + 2'd1;
            shreg <= {shreg[15:0], in_byte};
        end
    end

    // The word completes combinationally with its 4th byte so the
    // loader can register the write on that same accepting edge.
    assign word_valid = in_valid && (cnt == LAST);
    assign word       = {shreg, in_byte};

endmodule

// File: rtl/imem_loader.sv
// Boot loader: UART bytes -> 32-bit words -> IMEM, holds CPU in reset.
// Ports: clock, reset (sync, low), restart, bus (imem_loader_if.master),
// cpu_reset, load_done, load_error. Option: IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import loader_pkg::*;
#(
    parameter int ADDR_WIDTH     = 12,
    parameter int MAX_WORDS      = 4096,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           restart,
    imem_loader_if.master  bus,
    output logic           cpu_reset,
    output logic           load_done,
    output logic           load_error
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TONE  = TW'(1);
    localparam logic [ADDR_WIDTH:0] IDX_ONE = (ADDR_WIDTH+1)'(1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t S_TAIL = S_CHECK;
`else
    localparam state_t S_TAIL = S_FLUSH;
`endif

    state_t              state;
    logic [7:0]          len_hi;
    logic [15:0]         len;
    logic [ADDR_WIDTH:0] idx;
    logic [TW-1:0]       tcnt;

    logic        acc;
    logic        timed;
    logic        tout;
    logic        rearm;
    logic [15:0] n_rx;
    logic [16:0] idx_nx;
    logic        last_word;
    logic        pk_valid;
    logic [31:0] pk_word;

    assign bus.rx_ready = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                          (state == S_DATA)   || (state == S_CHECK);

    assign acc   = bus.rx_valid && bus.rx_ready;
    assign timed = (state == S_LEN_LO) || (state == S_DATA) ||
                   (state == S_CHECK);
    assign tout  = timed && !acc && (tcnt == TLAST);
    assign rearm = restart && ((state == S_DONE) || (state == S_ERROR));

    assign n_rx      = {len_hi, bus.rx_data};
    assign idx_nx    = 17'(idx) + 17'd1;
    assign last_word = (idx_nx == {1'b0, len});

    assign cpu_reset  = (state != S_DONE);
    assign load_done  = (state == S_DONE);
    assign load_error = (state == S_ERROR);

    loader_word_pack u_pack (
        .clock      (clock),
        .reset      (reset),
        .clear      (state != S_DATA),
        .in_valid   (acc && (state == S_DATA)),
        .in_byte    (bus.rx_data),
        .word_valid (pk_valid),
        .word       (pk_word)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum;

    always_ff @(posedge clock) begin
        if (!reset || rearm)
            csum <= '0;
        else if (acc && (state != S_CHECK))
            csum <= csum ^ bus.rx_data;
    end
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= S_LEN_HI;
            len_hi       <= '0;
            len          <= '0;
            idx          <= '0;
            tcnt         <= '0;
            bus.mem_wEn  <= 1'b0;
            bus.mem_addr <= '0;
            bus.mem_data <= '0;
        end else begin
            bus.mem_wEn <= 1'b0;

            if (timed && !acc)
                tcnt <= tcnt + TONE;
            else
                tcnt <= '0;

            unique case (state)
                S_LEN_HI: begin
                    if (acc) begin
                        len_hi <= bus.rx_data;
                        state  <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (acc) begin
                        len <= n_rx;
                        if ({16'd0, n_rx} > 32'(MAX_WORDS))
                            state <= S_ERROR;
                        else if (n_rx == 16'd0)
                            state <= S_TAIL;
                        else
                            state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (pk_valid) begin
                        bus.mem_wEn  <= 1'b1;
                        bus.mem_addr <= idx[ADDR_WIDTH-1:0];
                        bus.mem_data <= pk_word;
                        idx          <= idx + IDX_ONE;
                        if (last_word)
                            state <= S_TAIL;
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (acc)
                        state <= (bus.rx_data == csum) ? S_FLUSH : S_ERROR;
                end
`endif
                S_FLUSH: state <= S_DONE;
                S_DONE, S_ERROR: begin
                    if (restart) begin
                        state        <= S_LEN_HI;
                        len_hi       <= '0;
                        len          <= '0;
                        idx          <= '0;
                        bus.mem_addr <= '0;
                        bus.mem_data <= '0;
                    end
                end
                default: state <= S_ERROR;
            endcase

            // tout excludes accepting cycles, so it never races a transition.
            if (tout)
                state <= S_ERROR;
        end
    end

endmodule
